// File: rtl/noc_local_ni_if.sv
// Handshake bundle between the local NI, its core and the router LOCAL port.
// Combinational only: carries request, injection, ejection and response channels.
// Backpressure is plain valid/ready on every channel.
interface noc_local_ni_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 16
);
  // core -> NI request channel
  logic                  core_req_valid;
  logic                  core_req_ready;
  logic [DATA_WIDTH-1:0] core_req_data;
  logic [ADDR_WIDTH-1:0] core_req_dest;
  logic [2:0]            core_req_type;
  // NI -> router injection channel
  logic                  noc_valid_out;
  logic                  noc_ready_in;
  logic [DATA_WIDTH-1:0] noc_data_out;
  logic [ADDR_WIDTH-1:0] noc_dest_out;
  logic [2:0]            noc_type_out;
  // router -> NI ejection channel
  logic                  noc_valid_in;
  logic                  noc_ready_out;
  logic [DATA_WIDTH-1:0] noc_data_in;
  logic [ADDR_WIDTH-1:0] noc_dest_in;
  logic [2:0]            noc_type_in;
  // NI -> core response channel
  logic                  core_rsp_valid;
  logic                  core_rsp_ready;
  logic [DATA_WIDTH-1:0] core_rsp_data;
  logic [2:0]            core_rsp_type;

  // Environment side: the core plus the router LOCAL port.
  modport master (
    output core_req_valid, core_req_data, core_req_dest, core_req_type,
    input  core_req_ready,
    input  noc_valid_out, noc_data_out, noc_dest_out, noc_type_out,
    output noc_ready_in,
    output noc_valid_in, noc_data_in, noc_dest_in, noc_type_in,
    input  noc_ready_out,
    input  core_rsp_valid, core_rsp_data, core_rsp_type,
    output core_rsp_ready
  );

  // Network-interface side.
  modport slave (
    input  core_req_valid, core_req_data, core_req_dest, core_req_type,
    output core_req_ready,
    output noc_valid_out, noc_data_out, noc_dest_out, noc_type_out,
    input  noc_ready_in,
    input  noc_valid_in, noc_data_in, noc_dest_in, noc_type_in,
    output noc_ready_out,
    output core_rsp_valid, core_rsp_data, core_rsp_type,
    input  core_rsp_ready
  );
endinterface

// File: rtl/noc_local_ni.sv
// Local network interface: FWFT injection FIFO toward the router plus a one-entry ejection register toward the core.
// Latency: injection 1 cycle push-to-output when empty; ejection 1 cycle capture-to-response.
// Backpressure: core_req_ready drops when full or not in RUN; noc_ready_out drops while a response is held.
// Optional packet counters are enabled by defining NI_PKT_COUNT_EN.
module noc_local_ni #(
  parameter int                    DATA_WIDTH = 256,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] NODE_ID    = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ni_enable,
  noc_local_ni_if.slave  bus,
  output logic           ni_idle,
  output logic           err_misroute,
  output logic [15:0]    tx_count,
  output logic [15:0]    rx_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_dat_q  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_dest_q [FIFO_DEPTH];
  logic [2:0]            mem_type_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q;
  logic [2:0]            rsp_type_q;
  logic                  err_q;
  logic                  eject_cap, eject_hit;

  // ---------------- injection ----------------
  assign bus.core_req_ready = (state_q == RUN) && (count_q < CNT_W'(FIFO_DEPTH));
  assign push               = bus.core_req_valid && bus.core_req_ready;
  assign bus.noc_valid_out  = (count_q != '0);
  assign pop                = bus.noc_valid_out && bus.noc_ready_in;
  assign bus.noc_data_out   = mem_dat_q[rd_ptr_q];
  assign bus.noc_dest_out   = mem_dest_q[rd_ptr_q];
  assign bus.noc_type_out   = mem_type_q[rd_ptr_q];

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat_q[wr_ptr_q]  <= bus.core_req_data;
      mem_dest_q[wr_ptr_q] <= bus.core_req_dest;
      mem_type_q[wr_ptr_q] <= bus.core_req_type;
    end
  end

  // FIFO pointers and count; power-of-2 depth makes pointer overflow the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------- control FSM ----------------
  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state: re-enable wins over finishing the drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!ni_enable) state_d = DRAIN;
      DRAIN:   if (ni_enable) state_d = RUN;
               else if (count_d == '0) state_d = DRAINED;
      DRAINED: if (ni_enable) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign ni_idle = (state_q == DRAINED) && (count_q == '0);

  // ---------------- ejection ----------------
  assign bus.noc_ready_out  = !rsp_vld_q || bus.core_rsp_ready;
  assign eject_cap          = bus.noc_valid_in && bus.noc_ready_out;
  assign eject_hit          = (bus.noc_dest_in == NODE_ID);
  assign bus.core_rsp_valid = rsp_vld_q;
  assign bus.core_rsp_data  = rsp_dat_q;
  assign bus.core_rsp_type  = rsp_type_q;
  assign err_misroute       = err_q;

  // Response valid: a consumed entry clears, a matching capture sets.
  always_comb begin
    rsp_vld_d = rsp_vld_q;
    if (bus.core_rsp_ready)     rsp_vld_d = 1'b0;
    if (eject_cap && eject_hit) rsp_vld_d = 1'b1;
  end

  // Ejection register and the one-cycle misroute flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= '0;
      rsp_type_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      err_q     <= eject_cap && !eject_hit;
      if (eject_cap && eject_hit) begin
        rsp_dat_q  <= bus.noc_data_in;
        rsp_type_q <= bus.noc_type_in;
      end
    end
  end

  // ---------------- packet counters ----------------
`ifdef NI_PKT_COUNT_EN
  logic [15:0] tx_cnt_q, rx_cnt_q;

  // Saturating counters of injected and accepted-ejected flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (pop && (tx_cnt_q != 16'hFFFF)) tx_cnt_q <= tx_cnt_q + 16'd1;
      if (eject_cap && eject_hit && (rx_cnt_q != 16'hFFFF)) rx_cnt_q <= rx_cnt_q + 16'd1;
    end
  end

  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;
`else
  assign tx_count = '0;
  assign rx_count = '0;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed bench for noc_local_ni: injection ordering/backpressure, drain FSM,
// table-driven ejection vectors, counters and mid-traffic reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_noc_local_ni;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam logic [AW-1:0] NID = 16'h0102;
`ifdef NI_PKT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ni_enable;
  logic ni_idle, err_misroute;
  logic [15:0] tx_count, rx_count;

  int n_run  = 0;
  int n_fail = 0;

  noc_local_ni_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) nif ();

  noc_local_ni #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .NODE_ID(NID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ni_enable(ni_enable), .bus(nif),
    .ni_idle(ni_idle), .err_misroute(err_misroute),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [15:0] dest;
    logic [2:0]  typ;
    logic [63:0] dat;
    logic        rdy;
    logic        e_vld;
    logic [63:0] e_dat;
    logic [2:0]  e_typ;
    logic        e_err;
    logic        e_nro;
  } ej_vec_t;

  ej_vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [63:0] d, input logic [15:0] a, input logic [2:0] t);
    nif.core_req_valid = v;
    nif.core_req_data  = d;
    nif.core_req_dest  = a;
    nif.core_req_type  = t;
  endtask

  task automatic chk_head(input string nm, input logic [63:0] d);
    chk({nm, "_vld"}, 64'(nif.noc_valid_out), 64'd1);
    chk({nm, "_dat"}, nif.noc_data_out, d);
  endtask

  initial begin
    // vin  dest      typ    dat       rdy | vld e_dat     e_typ  err nro
    tbl[0] = '{1'b1, 16'h0102, 3'd2, 64'hA1, 1'b0, 1'b1, 64'hA1, 3'd2, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'h0102, 3'd5, 64'hA2, 1'b0, 1'b1, 64'hA1, 3'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 16'h0103, 3'd1, 64'hB1, 1'b0, 1'b1, 64'hA1, 3'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 16'h0000, 3'd0, 64'h00, 1'b1, 1'b0, 64'hA1, 3'd2, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 16'h0103, 3'd1, 64'hB1, 1'b0, 1'b0, 64'hA1, 3'd2, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 16'h0000, 3'd0, 64'h00, 1'b0, 1'b0, 64'hA1, 3'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 16'h0102, 3'd7, 64'hC1, 1'b1, 1'b1, 64'hC1, 3'd7, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 16'h0102, 3'd4, 64'hC2, 1'b1, 1'b1, 64'hC2, 3'd4, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 16'h0000, 3'd0, 64'hD0, 1'b1, 1'b0, 64'hC2, 3'd4, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 16'h0000, 3'd0, 64'h00, 1'b0, 1'b0, 64'hC2, 3'd4, 1'b0, 1'b1};

    rst_n = 1'b0;
    ni_enable = 1'b1;
    set_req(1'b0, 64'd0, 16'd0, 3'd0);
    nif.noc_ready_in   = 1'b0;
    nif.noc_valid_in   = 1'b0;
    nif.noc_data_in    = '0;
    nif.noc_dest_in    = '0;
    nif.noc_type_in    = '0;
    nif.core_rsp_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_noc_vld",   64'(nif.noc_valid_out),  64'd0);
    chk("rst_req_rdy",   64'(nif.core_req_ready), 64'd1);
    chk("rst_nro",       64'(nif.noc_ready_out),  64'd1);
    chk("rst_rsp_vld",   64'(nif.core_rsp_valid), 64'd0);
    chk("rst_err",       64'(err_misroute),       64'd0);
    chk("rst_idle",      64'(ni_idle),            64'd0);
    chk("rst_tx",        64'(tx_count),           64'd0);
    #10 rst_n = 1'b1;
    step();

    // Four back-to-back pushes with the router always ready.
    nif.noc_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 64'h100 + 64'(i), 16'h0305, 3'(i));
      step();
      chk_head("injA", 64'h100 + 64'(i));
      chk("injA_dest", 64'(nif.noc_dest_out), 64'h0305);
      chk("injA_type", 64'(nif.noc_type_out), 64'(i));
    end
    set_req(1'b0, 64'd0, 16'h0305, 3'd0);
    step();
    chk("injA_empty", 64'(nif.noc_valid_out), 64'd0);

    // Fill to full with the router stalled, fifth word waits.
    nif.noc_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 64'h200 + 64'(i), 16'h0102, 3'd1);
      chk("injB_rdy", 64'(nif.core_req_ready), 64'd1);
      step();
    end
    set_req(1'b1, 64'h204, 16'h0102, 3'd1);
    chk("injB_full", 64'(nif.core_req_ready), 64'd0);
    step();
    step();
    chk_head("injB_hold", 64'h200);
    chk("injB_still_full", 64'(nif.core_req_ready), 64'd0);
    nif.noc_ready_in = 1'b1;
    step();
    chk_head("injB_p1", 64'h201);
    chk("injB_rdy_back", 64'(nif.core_req_ready), 64'd1);
    step();
    set_req(1'b0, 64'd0, 16'd0, 3'd0);
    chk_head("injB_p2", 64'h202);
    step();
    chk_head("injB_p3", 64'h203);
    step();
    chk_head("injB_p4", 64'h204);
    step();
    chk("injB_empty", 64'(nif.noc_valid_out), 64'd0);

    // Drain with three entries held.
    nif.noc_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 64'h300 + 64'(i), 16'h0102, 3'd3);
      step();
    end
    set_req(1'b0, 64'd0, 16'd0, 3'd0);
    ni_enable = 1'b0;
    step();
    chk("drn_rdy", 64'(nif.core_req_ready), 64'd0);
    chk("drn_idle0", 64'(ni_idle), 64'd0);
    step();
    chk_head("drn_hold", 64'h300);
    nif.noc_ready_in = 1'b1;
    step();
    chk_head("drn_p1", 64'h301);
    step();
    chk_head("drn_p2", 64'h302);
    chk("drn_idle_p2", 64'(ni_idle), 64'd0);
    step();
    chk("drn_empty", 64'(nif.noc_valid_out), 64'd0);
    chk("drn_idle1", 64'(ni_idle), 64'd1);
    set_req(1'b1, 64'h3FF, 16'h0305, 3'd0);
    step();
    chk("drn_no_push", 64'(nif.noc_valid_out), 64'd0);
    set_req(1'b0, 64'd0, 16'd0, 3'd0);

    // Ejection vectors, run while the injection side is DRAINED.
    for (int i = 0; i < 10; i++) begin
      nif.noc_valid_in   = tbl[i].vin;
      nif.noc_dest_in    = tbl[i].dest;
      nif.noc_type_in    = tbl[i].typ;
      nif.noc_data_in    = tbl[i].dat;
      nif.core_rsp_ready = tbl[i].rdy;
      step();
      chk($sformatf("ej%0d_vld", i), 64'(nif.core_rsp_valid), 64'(tbl[i].e_vld));
      chk($sformatf("ej%0d_dat", i), nif.core_rsp_data,       tbl[i].e_dat);
      chk($sformatf("ej%0d_typ", i), 64'(nif.core_rsp_type),  64'(tbl[i].e_typ));
      chk($sformatf("ej%0d_err", i), 64'(err_misroute),       64'(tbl[i].e_err));
      chk($sformatf("ej%0d_nro", i), 64'(nif.noc_ready_out),  64'(tbl[i].e_nro));
    end
    chk("ej_idle_kept", 64'(ni_idle), 64'd1);

    ni_enable = 1'b1;
    step();
    chk("ren_rdy", 64'(nif.core_req_ready), 64'd1);
    chk("ren_idle0", 64'(ni_idle), 64'd0);

    // DRAIN back to RUN before the FIFO empties.
    nif.noc_ready_in = 1'b0;
    set_req(1'b1, 64'h400, 16'h0102, 3'd6);
    step();
    set_req(1'b0, 64'd0, 16'd0, 3'd0);
    ni_enable = 1'b0;
    step();
    chk("d2r_rdy0", 64'(nif.core_req_ready), 64'd0);
    ni_enable = 1'b1;
    step();
    chk("d2r_rdy1", 64'(nif.core_req_ready), 64'd1);
    chk_head("d2r_head", 64'h400);
    chk("d2r_self_dest", 64'(nif.noc_dest_out), 64'h0102);
    nif.noc_ready_in = 1'b1;
    step();
    chk("d2r_empty", 64'(nif.noc_valid_out), 64'd0);

    chk("cnt_tx", 64'(tx_count), CNT_EN ? 64'd13 : 64'd0);
    chk("cnt_rx", 64'(rx_count), CNT_EN ? 64'd3  : 64'd0);

    // Reset in the middle of traffic.
    nif.noc_ready_in = 1'b0;
    nif.core_rsp_ready = 1'b0;
    set_req(1'b1, 64'h500, 16'h0305, 3'd1);
    nif.noc_valid_in = 1'b1;
    nif.noc_dest_in  = NID;
    nif.noc_data_in  = 64'h5EE;
    step();
    nif.noc_valid_in = 1'b0;
    set_req(1'b1, 64'h501, 16'h0305, 3'd1);
    step();
    set_req(1'b0, 64'd0, 16'd0, 3'd0);
    chk("mr_pre_vld", 64'(nif.noc_valid_out), 64'd1);
    chk("mr_pre_rsp", 64'(nif.core_rsp_valid), 64'd1);
    chk("mr_pre_rx", 64'(rx_count), CNT_EN ? 64'd4 : 64'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("mr_vld",     64'(nif.noc_valid_out),  64'd0);
    chk("mr_rsp",     64'(nif.core_rsp_valid), 64'd0);
    chk("mr_tx",      64'(tx_count),           64'd0);
    chk("mr_rx",      64'(rx_count),           64'd0);
    chk("mr_req_rdy", 64'(nif.core_req_ready), 64'd1);
    chk("mr_nro",     64'(nif.noc_ready_out),  64'd1);
    #3 rst_n = 1'b1;
    nif.noc_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_vld", i), 64'(nif.noc_valid_out), 64'd0);
      chk($sformatf("post_rst%0d_rsp", i), 64'(nif.core_rsp_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_local_ni.md
NOC_LOCAL_NI -- requirements
Module: noc_local_ni

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 256, flit payload width; ADDR_WIDTH, default 16, destination address {y[15:8],x[7:0]}; FIFO_DEPTH, default 4, injection FIFO entries (power of 2, 2..16); NODE_ID, default 0, own mesh address.
REQ-002 SHALL have ports (clk and rst_n first):
 clk  in  1  sole clock, rising edge;
 rst_n  in  1  asynchronous active-low reset;
 ni_enable  in  1  1 = accept core requests, 0 = drain and stop;
 core_req_valid  in  1  core injection request;
 core_req_ready  out  1  injection FIFO can accept;
 core_req_data  in  DATA_WIDTH  payload;
 core_req_dest  in  ADDR_WIDTH  destination address;
 core_req_type  in  3  packet type;
 noc_valid_out  out  1  flit to router LOCAL input;
 noc_ready_in  in  1  router LOCAL input ready;
 noc_data_out  out  DATA_WIDTH;  noc_dest_out  out  ADDR_WIDTH;  noc_type_out  out  3;
 noc_valid_in  in  1  flit from router LOCAL output;
 noc_ready_out  out  1  ejection can accept;
 noc_data_in  in  DATA_WIDTH;  noc_dest_in  in  ADDR_WIDTH;  noc_type_in  in  3;
 core_rsp_valid  out  1;  core_rsp_ready  in  1;  core_rsp_data  out  DATA_WIDTH;  core_rsp_type  out  3;
 ni_idle  out  1  injection FIFO empty and state DRAINED;
 err_misroute  out  1  one-cycle pulse, ejected flit not addressed to NODE_ID;
 tx_count  out  16;  rx_count  out  16  packet counters.
REQ-003 Clock is clk only; reset is rst_n, asynchronous assert, active-low.

Function
REQ-004 Injection FIFO SHALL be first-word-fall-through; noc_valid_out = (count != 0); noc_*_out = head entry, stable while noc_valid_out && !noc_ready_in.
REQ-005 Push on core_req_valid && core_req_ready; pop on noc_valid_out && noc_ready_in; simultaneous push/pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-006 core_req_ready = (state == RUN) && (count < FIFO_DEPTH); no push when full, even if popping same cycle.
REQ-007 Injection latency: pushed word visible on noc_*_out the cycle after push when FIFO was empty.
REQ-008 Control FSM states RUN, DRAIN, DRAINED: RUN->DRAIN when ni_enable=0; DRAIN->DRAINED when count==0 (including count reaching 0 that cycle); DRAINED->RUN when ni_enable=1; DRAIN->RUN when ni_enable=1 before empty.
REQ-009 ni_idle = (state == DRAINED) && (count == 0), registered-state derived, no input combinational path.
REQ-010 Ejection SHALL be a single output register: noc_ready_out = !core_rsp_valid || core_rsp_ready; capture on noc_valid_in && noc_ready_out.
REQ-011 Captured flit with noc_dest_in == NODE_ID: core_rsp_valid=1 next cycle, data/type from flit; held until core_rsp_ready.
REQ-012 Flit with noc_dest_in != NODE_ID: dropped (core_rsp_valid not set by it), err_misroute=1 for exactly the next cycle.
REQ-013 Ejection operates in all FSM states; ni_enable affects injection only.
REQ-014 Self-addressed requests (core_req_dest == NODE_ID) SHALL be injected to the router unchanged.

Reset
REQ-015 On rst_n=0: FIFO pointers/count=0, state=RUN, noc_valid_out=0, core_rsp_valid=0, err_misroute=0, tx_count=0, rx_count=0; core_req_ready=1 and noc_ready_out=1 after reset.
REQ-016 Reset mid-transfer SHALL discard all FIFO and ejection contents; no flit emitted after release until a new push.

Configuration
REQ-017 Macro NI_PKT_COUNT_EN defined: tx_count increments per injection pop, rx_count per accepted (non-misrouted) ejection, both saturate at 16'hFFFF.
REQ-018 NI_PKT_COUNT_EN undefined: no counter registers; tx_count and rx_count tied to 0; all other behaviour identical.

Verification
REQ-019 Reset, NODE_ID=16'h0102, push 4 words dest 16'h0305, noc_ready_in=1 -> noc_valid_out for 4 consecutive cycles starting 1 cycle after first push, order preserved.
REQ-020 noc_ready_in=0, push 5 words -> core_req_ready=0 after 4th push; 5th held; release -> 4 pops then 5th accepted.
REQ-021 FIFO holds 3 entries, ni_enable=0 -> core_req_ready=0, state DRAIN, ni_idle=1 cycle after 3rd pop; ni_enable=1 -> core_req_ready=1.
REQ-022 Eject dest 16'h0102 type 3'b010 with core_rsp_ready=0 -> core_rsp_valid held, noc_ready_out=0; eject dest 16'h0103 -> dropped, err_misroute single-cycle pulse.
REQ-023 With NI_PKT_COUNT_EN: 3 injections, 2 valid ejections -> tx_count=3, rx_count=2; assert rst_n mid-burst -> both 0, noc_valid_out=0.
